// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// the packed bundle of register controls and the RUN-state control decoder.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_flush;
    } ctrl_t;

    // Bit order follows the struct: pc_en is the MSB, mem_wb_flush the LSB.
    localparam ctrl_t CTRL_RESET     = ctrl_t'(8'b0010_1001);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'b0000_0001);
    localparam ctrl_t CTRL_REDIRECT  = ctrl_t'(8'b1111_1110);
    localparam ctrl_t CTRL_STALL     = ctrl_t'(8'b0001_1110);
    localparam ctrl_t CTRL_IDLE      = ctrl_t'(8'b1101_0110);
    localparam ctrl_t CTRL_HALT      = ctrl_t'(8'b0000_0000);

    // A redirect already kills the stalled ID instruction, so it outranks stall_req.
    function automatic ctrl_t run_ctrl(input logic [1:0] stall_req, input logic redirect);
        if (redirect)
            return CTRL_REDIRECT;
        else if (stall_req != 2'b00)
            return CTRL_STALL;
        else
            return CTRL_IDLE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter used for the stall and flush performance counters.
module pipe_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges hazard stalls, EX redirects and the
// data-memory handshake into per-register enables/flushes; traps on hung memory.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       stall_req,
    input  logic             redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             trap,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int   WAIT_W     = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    ctrl_state_t       state, next_state;
    ctrl_t             ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              trap_q;
    logic              flush_inc;
    logic              stall_inc;

    always_comb begin
        ctrl       = CTRL_HALT;
        next_state = state;
        flush_inc  = 1'b0;
        if (!rstn) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        ctrl       = CTRL_MEM_STALL;
                        next_state = ST_MEM_WAIT;
                    end else begin
                        ctrl      = run_ctrl(stall_req, redirect);
                        flush_inc = redirect;
                    end
                end
                // Redirect and stalls are held off while memory is busy and re-present on ack.
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        ctrl       = run_ctrl(stall_req, redirect);
                        flush_inc  = redirect;
                        next_state = ST_RUN;
                    end else begin
                        ctrl = CTRL_MEM_STALL;
                        if (TIMEOUT_EN && (wait_cnt == WAIT_W'(MEM_TIMEOUT)))
                            next_state = ST_TRAP;
                    end
                end
                ST_TRAP: ctrl = CTRL_HALT;
                default: next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_RUN) && (next_state == ST_MEM_WAIT))
                wait_cnt <= WAIT_W'(1);
            else if ((state == ST_MEM_WAIT) && !dmem_ack && (wait_cnt != {WAIT_W{1'b1}}))
                wait_cnt <= wait_cnt + 1'b1;
            if (next_state == ST_TRAP)
                trap_q <= 1'b1;
        end
    end

    assign stall_inc = rstn && !ctrl.pc_en;

    pipe_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    pipe_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign trap         = trap_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: short timeout and narrow counters so trap
// and counter saturation are reachable in a few hundred cycles.
module tb_pipe_ctrl;

    localparam int CNT_W = 8;

    // Packed {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_en,mem_wb_flush}
    localparam logic [7:0] EXP_RESET    = 8'b0010_1001;
    localparam logic [7:0] EXP_MEMSTALL = 8'b0000_0001;
    localparam logic [7:0] EXP_REDIRECT = 8'b1111_1110;
    localparam logic [7:0] EXP_STALL    = 8'b0001_1110;
    localparam logic [7:0] EXP_IDLE     = 8'b1101_0110;
    localparam logic [7:0] EXP_HALT     = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       stall_req;
    logic             redirect;
    logic             dmem_req;
    logic             dmem_ack;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, mem_wb_en, mem_wb_flush, trap;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0]       ctrl_vec;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall_req    (stall_req),
        .redirect     (redirect),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_flush (mem_wb_flush),
        .trap         (trap),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                       ex_mem_en, mem_wb_en, mem_wb_flush};

    task automatic applyStimulus(input logic [1:0] s, input logic r, input logic q, input logic a);
        stall_req = s;
        redirect  = r;
        dmem_req  = q;
        dmem_ack  = a;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_ctrl", 32'(ctrl_vec), 32'(EXP_RESET));
        checkOutput("reset_trap", 32'(trap), 32'd0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        stepCycle();
        stepCycle();
        @(negedge clk);
        rstn = 1'b1;
        stepCycle();

        // Idle pipeline
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
            checkOutput("idle_ctrl", 32'(ctrl_vec), 32'(EXP_IDLE));
            stepCycle();
        end
        checkOutput("idle_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("idle_flush_cnt", 32'(flush_cnt), 32'd0);

        // Hazard stall from EX for two cycles
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b10, 1'b0, 1'b0, 1'b0);
            checkOutput("stall_ctrl", 32'(ctrl_vec), 32'(EXP_STALL));
            stepCycle();
        end
        checkOutput("stall_cnt_2", 32'(stall_cnt), 32'd2);

        // Redirect outranks a simultaneous ID stall
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("redirect_ctrl", 32'(ctrl_vec), 32'(EXP_REDIRECT));
        stepCycle();
        checkOutput("redirect_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("redirect_stall_cnt", 32'(stall_cnt), 32'd2);

        // Memory access acked on the fourth cycle; redirect held during the wait
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("mem_first_ctrl", 32'(ctrl_vec), 32'(EXP_MEMSTALL));
        stepCycle();
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
        checkOutput("mem_wait_ctrl", 32'(ctrl_vec), 32'(EXP_MEMSTALL));
        stepCycle();
        checkOutput("mem_wait_flush_cnt", 32'(flush_cnt), 32'd1);
        applyStimulus(2'b10, 1'b0, 1'b1, 1'b0);
        checkOutput("mem_wait_stall_held", 32'(ctrl_vec), 32'(EXP_MEMSTALL));
        stepCycle();
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b1);
        checkOutput("mem_ack_ctrl", 32'(ctrl_vec), 32'(EXP_REDIRECT));
        stepCycle();
        checkOutput("mem_stall_cnt", 32'(stall_cnt), 32'd5);
        checkOutput("mem_flush_cnt", 32'(flush_cnt), 32'd2);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("mem_back_to_run", 32'(ctrl_vec), 32'(EXP_IDLE));
        stepCycle();

        // Stray ack in RUN does nothing
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("stray_ack_ctrl", 32'(ctrl_vec), 32'(EXP_IDLE));
        stepCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("stray_ack_after", 32'(ctrl_vec), 32'(EXP_MEMSTALL));

        // Hung access: 1 RUN cycle + 4 wait cycles, then TRAP
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("pre_trap_flag", 32'(trap), 32'd0);
        checkOutput("pre_trap_ctrl", 32'(ctrl_vec), 32'(EXP_MEMSTALL));
        stepCycle();
        checkOutput("trap_flag", 32'(trap), 32'd1);
        checkOutput("trap_ctrl", 32'(ctrl_vec), 32'(EXP_HALT));
        checkOutput("trap_stall_cnt", 32'(stall_cnt), 32'd10);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("trap_req_dropped_ctrl", 32'(ctrl_vec), 32'(EXP_HALT));
        stepCycle();
        checkOutput("trap_sticky", 32'(trap), 32'd1);
        checkOutput("trap_no_flush_count", 32'(flush_cnt), 32'd2);

        // Stall counter saturates while trapped
        for (int i = 0; i < 300; i++) stepCycle();
        checkOutput("stall_cnt_saturate", 32'(stall_cnt), 32'd255);
        checkOutput("trap_still_set", 32'(trap), 32'd1);

        // Reset clears the trap
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("trap_reset_flag", 32'(trap), 32'd0);
        checkOutput("trap_reset_cnt", 32'(stall_cnt), 32'd0);
        rstn = 1'b1;
        stepCycle();

        // Async reset in the middle of a memory wait
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("midreset_wait_ctrl", 32'(ctrl_vec), 32'(EXP_MEMSTALL));
        checkOutput("midreset_pre_cnt", 32'(stall_cnt), 32'd2);
        rstn = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 32'(ctrl_vec), 32'(EXP_RESET));
        checkOutput("midreset_cnt", 32'(stall_cnt), 32'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        #1;
        checkOutput("midreset_release_ctrl", 32'(ctrl_vec), 32'(EXP_IDLE));
        stepCycle();
        checkOutput("midreset_run_ctrl", 32'(ctrl_vec), 32'(EXP_IDLE));
        checkOutput("midreset_run_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("midreset_trap", 32'(trap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
